// File: rtl/cpu_pkg.sv
// Shared constants, instruction field positions and run-control state type
// for the single-cycle core front end.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_HALT = 6'd63;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } run_state_t;

endpackage

// File: rtl/reg_file.sv
// 32x32 architectural register file: two asynchronous read ports, one
// synchronous write port, r0 hardwired to zero.
module reg_file
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] regs_q [32];

    // NOTE: unlike most storage arrays this one is cleared on reset, because
    // the architecture defines every register as zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/fetch_decode.sv
// Front end of the single-cycle core: PC, instruction memory, register file
// and the IDLE/RUN/HALT run-control FSM; commits execute's results each edge.
module fetch_decode
    import cpu_pkg::*;
#(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_en,
    input  logic [IMEM_AW-1:0] load_addr,
    input  logic [XLEN-1:0]    load_data,
    input  logic               run,
    input  logic [4:0]         wra,
    input  logic [XLEN-1:0]    result,
    input  logic [XLEN-1:0]    nextpc,
    output logic [XLEN-1:0]    ins,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    reg1,
    output logic [XLEN-1:0]    reg2,
    output logic               running,
    output logic               halted,
    output logic [XLEN-1:0]    icount
);

    run_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] icount_q, icount_d;
    logic            rf_we;
    logic            is_halt;

    logic [XLEN-1:0] imem [2**IMEM_AW];

    // NOTE: the instruction memory has no reset; its contents are defined
    // solely by program loads.
    always_ff @(posedge clk) begin
        if (load_en && (state_q != RUN)) begin
            imem[load_addr] <= load_data;
        end
    end

    assign ins     = imem[pc_q[IMEM_AW-1:0]];
    assign is_halt = (ins[OP_MSB:OP_LSB] == OP_HALT);

    // NOTE: every variable is given a default before the case so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        rf_we    = 1'b0;
        unique case (state_q)
            IDLE, HALT: begin
                if (run) begin
                    state_d  = RUN;
                    pc_d     = '0;
                    icount_d = '0;
                end
            end
            RUN: begin
                if (is_halt) begin
                    state_d = HALT;
                end else begin
                    pc_d     = nextpc;
                    icount_d = icount_q + 32'd1;
                    rf_we    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
        end
    end

    reg_file u_reg_file (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (rf_we),
        .wa_i  (wra),
        .wd_i  (result),
        .ra1_i (ins[RS_MSB:RS_LSB]),
        .ra2_i (ins[RT_MSB:RT_LSB]),
        .rd1_o (reg1),
        .rd2_o (reg2)
    );

    assign pc      = pc_q;
    assign icount  = icount_q;
    assign running = (state_q == RUN);
    assign halted  = (state_q == HALT);

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front end and architectural state of the single-cycle core. The block holds the PC, the instruction memory and the 32×32 register file. Each cycle it presents `ins`, `pc`, `reg1` and `reg2` to `execute`. On the next clock edge it commits `execute`'s `nextpc` and its `wra`/`result` writeback. A small run-control FSM covers program loading, start and halt.

## Interface
Parameters:
- `IMEM_AW`, default 8: instruction memory address width (depth 2^IMEM_AW words).

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `load_en`  in  1: program-load write strobe; honoured in IDLE and HALT only.
- `load_addr`  in  IMEM_AW: instruction memory word address for the load.
- `load_data`  in  32: instruction word to load.
- `run`  in  1: start pulse; honoured in IDLE and HALT only.
- `wra`  in  5: writeback register address from `execute`.
- `result`  in  32: writeback data from `execute`.
- `nextpc`  in  32: next PC from `execute`.
- `ins`  out  32: current instruction, `imem[pc[IMEM_AW-1:0]]`.
- `pc`  out  32: current PC (word address).
- `reg1`  out  32: `regs[ins[25:21]]` (rs).
- `reg2`  out  32: `regs[ins[20:16]]` (rt).
- `running`  out  1: high in RUN.
- `halted`  out  1: high in HALT.
- `icount`  out  32: number of instructions retired since the last reset or `run`.

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE → RUN when `run` is high.
  - RUN → HALT when `ins[31:26] == OP_HALT` (6'd63).
  - HALT → RUN when `run` is high.
  - There is no RUN → IDLE transition except reset.
- Entering RUN: `pc` ← 0 and `icount` ← 0. Registers are not cleared.
- Each RUN cycle with a non-halt instruction:
  - `pc` ← `nextpc`.
  - `icount` ← `icount + 1`, wrapping mod 2^32.
  - `regs[wra]` ← `result` if `wra != 0`.
- Halt instruction:
  - No register write, `pc` holds, `icount` is not incremented.
  - `pc` remains on the halt word while halted.
- In IDLE and HALT:
  - `pc`, `regs` and `icount` hold.
  - `nextpc`, `wra` and `result` are ignored.
- Instruction load:
  - `imem[load_addr]` ← `load_data` when `load_en` is high and the state is not RUN.
  - `load_en` is ignored in RUN.
- Register 0 reads as 0 always and is never written. `execute` reports `wra = 0` for non-writing ops; no separate write enable exists.
- Reads of `ins`, `reg1` and `reg2` are asynchronous. A write at edge N is visible after edge N. No bypass is needed.
- PC wrap: only `pc[IMEM_AW-1:0]` indexes imem, so `pc = 0x100` aliases to word 0 when IMEM_AW=8. The full 32-bit `pc` is still output.

## Timing
- Reset values:
  - State IDLE.
  - `pc` = 0, all `regs` = 0, `icount` = 0.
  - `running` = 0, `halted` = 0.
  - imem is not reset.
  - `ins`, `reg1` and `reg2` follow from these values.
- `run` sampled at edge N: state is RUN and `pc` = 0 after edge N. The first instruction commits at edge N+1.
- `load_en` and `run` high in the same IDLE cycle: the load completes at the same edge. A load to address 0 is the word executed first.
- One instruction retires per RUN cycle; latency from `ins` valid to writeback is one edge.
- Reset asserted mid-RUN: the next edge forces all reset values, and the pending writeback is dropped.
- `run` asserted while in RUN is ignored.

## Structure
- Package `cpu_pkg`:
  - `OP_HALT` = 6'd63.
  - Field slice positions: `OP_MSB`/`OP_LSB`, rs 25:21, rt 20:16.
  - State enum `run_state_t` {IDLE, RUN, HALT}.
  - `XLEN` = 32.
- Sub-module `reg_file`:
  - 32×32 registers.
  - Two asynchronous read ports, one synchronous write port.
  - r0 hardwired to 0.
  - Synchronous active-low reset clears all registers.
- The FSM, PC register, `icount` counter and imem array live in `fetch_decode`.

## Test plan
The bench drives `wra`, `result` and `nextpc` as an `execute` model.
- Reset → `pc` = 0, `icount` = 0, `running` = 0, `halted` = 0, `reg1` = `reg2` = 0.
- Load imem[0] = 0x04010005 (addi r1,r0,5) and imem[1] = 0xFC000000, then pulse `run`. Bench returns `wra` = 1, `result` = 5, `nextpc` = 1. Required: `halted` = 1 at the second post-run edge, `icount` = 1, `pc` = 1, r1 = 5 (visible on `reg1` when `ins` has rs = 1).
- In RUN, `wra` = 0 with `result` = 0xDEADBEEF → r0 still reads 0. `load_en` to address 3 during RUN → imem[3] unchanged.
- Branch and wrap: `nextpc` = 0x100 with IMEM_AW = 8 → `pc` = 0x100 and `ins` = imem[0].
- Reset asserted for one cycle mid-RUN with `wra` = 2 → r2 = 0, state IDLE, `pc` = 0. `run` from HALT → restart at `pc` = 0, `icount` = 0, registers retain their values.
